aes256_block_serializer: RTL
============================

# aes256_block_serializer

Parametrised output buffer for the AES-256 datapath. It captures 128-bit ciphertext blocks strobed out of the encryption core and queues them in a DEPTH-entry FIFO. It then serialises each block onto an OUT_W-bit request/response readout port. It replaces the fixed single-block, byte-wide data loading stage and adds multi-block buffering, selectable word width and order, and overflow reporting.

## Interface
- OUT_W, 8, readout word width; legal values 8/16/32/64/128; WORDS = 128/OUT_W.
- DEPTH, 4, FIFO depth in 128-bit blocks; power of two, ≥ 2.
- MSB_FIRST, 1, 1: word 0 = in_data[127 -: OUT_W]; 0: word 0 = in_data[OUT_W-1:0].
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle strobe (enc_done); in_data captured when asserted.
- in_data  in  128  ciphertext block.
- in_ready  out  1  FIFO not full; advisory only, the producer does not stall.
- next_val_req  in  1  request for the next output word; single-cycle pulse or held high.
- next_val_ready  out  1  registered; data_out valid this cycle.
- data_out  out  OUT_W  registered output word.
- last_word  out  1  qualifies next_val_ready; word is the final word of its block.
- block_count  out  $clog2(DEPTH)+1  blocks currently stored, including a partially read block.
- overflow  out  1  sticky; a block was dropped because the FIFO was full.

## Operation
- Storage: DEPTH×128 RAM/regs, wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; count of $clog2(DEPTH)+1 bits.
- Write: in_valid && count<DEPTH → mem[wr_ptr]=in_data, wr_ptr++. in_valid && count==DEPTH → no write, overflow←1 (held until rst).
- Read FSM, states:
  - EMPTY: count==0. Requests are ignored: no response, no error, no queuing.
  - SERVE: count>0.
- In SERVE, next_val_req=1 → next cycle: next_val_ready=1, data_out = word[widx] of mem[rd_ptr], widx++.
- widx: $clog2(WORDS)-bit counter, fixed 0 when WORDS==1.
- widx==WORDS-1 on a served request → last_word=1, widx←0, rd_ptr++, count decrements (pop).
- Word selection: MSB_FIRST=1 → word[k] = in_data[127-k*OUT_W -: OUT_W]; MSB_FIRST=0 → word[k] = in_data[k*OUT_W +: OUT_W].
- Simultaneous push and pop in one cycle → count unchanged, both pointers advance.
- Push when count==DEPTH while a pop occurs in the same cycle → still dropped and flagged. The full check uses the registered count; there is no bypass.
- in_ready = !rst && (count<DEPTH).
- No mid-block abort; a partially read block stays at the head until all WORDS are read.

## Timing
- Reset (rst high at edge), all registers cleared:
  - next_val_ready=0, data_out=0, last_word=0, block_count=0, overflow=0;
  - pointers=0, widx=0, FSM=EMPTY.
- Asserting rst mid-block discards all stored data, including the partially read block.
- in_ready=0 while rst is high; 1 in the first cycle after.
- Write latency: in_valid at edge N → block_count updated after edge N; the earliest accepted request is at edge N+1 → next_val_ready at N+2.
- Read latency: request sampled at edge M → next_val_ready/data_out valid for exactly the cycle after edge M (M+1).
- With no request, next_val_ready=0 and data_out holds its last value.
- next_val_req held high → one word per cycle; throughput one OUT_W word per clock.
- Block boundary: the last word of block i at edge M is followed by word 0 of block i+1 at edge M+1 with no bubble, provided block i+1 was written at or before edge M-1.
- A request at edge M when count==1 and the last word is being served yields nothing at M+1 unless a new block was written before edge M.
- last_word is asserted only together with next_val_ready.

## Test plan
- OUT_W=8, MSB_FIRST=1; push 0x8ea2b7ca516745bfeafc49904b496089 (FIPS-197 AES-256 ciphertext); hold req for 16 cycles → bytes 8e,a2,b7,…,60,89; last_word only on 0x89; block_count goes 1→0 after the 16th byte.
- OUT_W=32, MSB_FIRST=1, same block → 8ea2b7ca, 516745bf, eafc4990, 4b496089. OUT_W=8, MSB_FIRST=0 → first byte 0x89, last byte 0x8e.
- DEPTH=4, OUT_W=8; push 5 blocks back-to-back without reads:
  - after the 4th push → in_ready=0, block_count=4;
  - 5th push dropped, overflow=1;
  - 64 requests return blocks 1–4 in order; block 5 never appears;
  - overflow stays 1 until rst.
- Requests on an empty FIFO for 10 cycles → no next_val_ready. Push a block at edge N with req held → first word at N+2.
- Continuous req spanning 2 blocks (OUT_W=8) → 32 consecutive ready cycles, no bubble. A push at the exact cycle of the 16th pop keeps block_count=1 and advances both pointers.
- rst asserted after 5 of 16 bytes are read → next cycle all outputs 0, block_count=0; a new block then reads out from word 0.

Source files
------------

// File: rtl/aes256_block_serializer.sv
// rtl/aes256_block_serializer.sv - DEPTH-block ciphertext FIFO serialised onto an OUT_W-bit request/response port
module aes256_block_serializer #(
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [127:0]             in_data,
  output logic                     in_ready,
  input  logic                     next_val_req,
  output logic                     next_val_ready,
  output logic [OUT_W-1:0]         data_out,
  output logic                     last_word,
  output logic [$clog2(DEPTH):0]   block_count,
  output logic                     overflow
);

  localparam int WORDS  = 128 / OUT_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

  typedef enum logic {EMPTY, SERVE} state_t;
  state_t state, state_next;

  logic [127:0]      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [WIDX_W-1:0] widx, widx_next;
  logic              push, serve, pop;
  logic [OUT_W-1:0]  word;
  int                shamt;

  // Full check uses the registered count only; a same-cycle pop does not free a slot.
  always_comb begin
    push       = in_valid && (count != FULL);
    serve      = (state == SERVE) && next_val_req;
    pop        = serve && (widx == LAST_IDX);
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
    state_next = (count_next == '0) ? EMPTY : SERVE;
    widx_next  = widx;
    if (serve) begin
      widx_next = pop ? '0 : widx + 1'b1;
    end
  end

  always_comb begin
    shamt = 0;
    if (MSB_FIRST) begin
      shamt = 128 - OUT_W * (int'(widx) + 1);
    end else begin
      shamt = OUT_W * int'(widx);
    end
    word = OUT_W'(mem[rd_ptr] >> shamt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      widx           <= '0;
      next_val_ready <= 1'b0;
      data_out       <= '0;
      last_word      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      count          <= count_next;
      widx           <= widx_next;
      next_val_ready <= serve;
      last_word      <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
      if (serve) begin
        data_out <= word;
      end
    end
  end

  assign in_ready    = !rst && (count != FULL);
  assign block_count = count;

endmodule
